// File: rtl/bsg_round_robin_n_to_1_pkt_if.sv
// ---------------------------------------------------------------------------
// bsg_round_robin_n_to_1_pkt_if
//
// Purpose:
//   Bundles the handshake and data signals around the packet-aware
//   N-to-1 round-robin arbiter. The N input streams and the single merged
//   output stream share one interface instance.
//
// Parameters:
//   els_p    number of input streams (>= 2)
//   width_p  data width of each stream
//
// Signals:
//   valid_i [els_p]          per-input valid
//   data_i  [els_p*width_p]  input i occupies [i*width_p +: width_p]
//   last_i  [els_p]          per-input end-of-packet marker
//   ready_o [els_p]          per-input ready
//   valid_o                  merged output valid
//   data_o  [width_p]        granted input's data
//   last_o                   granted input's last marker
//   tag_o   [lg_els_lp]      index of the granted input
//   ready_i                  merged output ready
//
// Modports:
//   slave   the arbiter's view (consumes inputs, produces the merged stream)
//   master  the environment's view (drives inputs, consumes the merged stream)
// ---------------------------------------------------------------------------
interface bsg_round_robin_n_to_1_pkt_if #(
  parameter int els_p   = 2,
  parameter int width_p = 8
);

  localparam int lg_els_lp = $clog2(els_p);

  logic [els_p-1:0]         valid_i;
  logic [els_p*width_p-1:0] data_i;
  logic [els_p-1:0]         last_i;
  logic [els_p-1:0]         ready_o;
  logic                     valid_o;
  logic [width_p-1:0]       data_o;
  logic                     last_o;
  logic [lg_els_lp-1:0]     tag_o;
  logic                     ready_i;

  modport slave (
    input  valid_i,
    input  data_i,
    input  last_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o,
    output last_o,
    output tag_o
  );

  modport master (
    output valid_i,
    output data_i,
    output last_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o,
    input  last_o,
    input  tag_o
  );

endinterface

// File: rtl/bsg_round_robin_n_to_1_pkt.sv
// ---------------------------------------------------------------------------
// bsg_round_robin_n_to_1_pkt
//
// Purpose:
//   Packet-aware round-robin arbiter merging els_p ready/valid streams onto
//   one output stream. A multi-beat packet keeps the grant until its last
//   beat is accepted, so packets from different inputs never interleave.
//   Input to output is purely combinational (zero-cycle latency); grant
//   decisions are registered on the clock edge where the handshake occurs.
//
// Parameters:
//   els_p        number of inputs (>= 2)
//   width_p      data width per input
//   max_beats_p  packet-length limit, only used with BSG_RR_PKT_LEN_CHECK_EN
//
// Ports:
//   clk_i       clock, rising edge
//   reset_i     synchronous active-high reset
//   bus         slave modport of bsg_round_robin_n_to_1_pkt_if carrying the
//               per-input valid/data/last/ready and the merged
//               valid/data/last/tag/ready
//   overlong_o  sticky packet-length error flag
//
// Configuration macro:
//   BSG_RR_PKT_LEN_CHECK_EN  when defined, packets are limited to
//   max_beats_p beats; an overlong packet is force-released after its
//   max_beats_p-th beat and overlong_o is set until reset. When undefined,
//   packets are unbounded and overlong_o is constant 0.
// ---------------------------------------------------------------------------
module bsg_round_robin_n_to_1_pkt #(
  parameter int els_p       = 2,
  parameter int width_p     = 8,
  parameter int max_beats_p = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  bsg_round_robin_n_to_1_pkt_if.slave     bus,
  output logic                            overlong_o
);

  localparam int lg_els_lp = $clog2(els_p);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [lg_els_lp-1:0] r_ptr;
  logic [lg_els_lp-1:0] r_grant;

  logic                 w_found;
  logic [lg_els_lp-1:0] w_search;
  logic [lg_els_lp-1:0] w_g;
  logic [lg_els_lp-1:0] w_g_inc;
  logic                 w_valid;
  logic                 w_last;
  logic [width_p-1:0]   w_data;
  logic                 w_accept;
  logic                 w_release;
  logic                 w_force;

  // Round-robin search: walk the inputs starting at r_ptr, wrapping from
  // els_p-1 back to 0, and remember the first valid one. The wrap is an
  // explicit compare so that non-power-of-two els_p never visits an index
  // that does not exist. When nothing is valid the search result falls back
  // to r_ptr, which is what tag_o must show while idle.
  always_comb begin
    logic [lg_els_lp-1:0] idx;
    w_found  = 1'b0;
    w_search = r_ptr;
    idx      = r_ptr;
    for (int k = 0; k < els_p; k++) begin
      if (!w_found && bus.valid_i[idx]) begin
        w_found  = 1'b1;
        w_search = idx;
      end
      idx = (idx == lg_els_lp'(els_p - 1)) ? '0 : idx + lg_els_lp'(1);
    end
  end

  // Output process: pick the active grant (search result while idle, the
  // held grant while locked), steer its data/last onto the output and
  // compute per-input readies. Only the granted input can ever see ready;
  // while locked it sees ready even during its own bubbles so the upstream
  // handshake stays simple. valid_o, data_o and tag_o never look at ready_i.
  always_comb begin
    w_g     = r_grant;
    w_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_g     = w_found ? w_search : r_ptr;
        w_valid = |bus.valid_i;
      end
      LOCKED: begin
        w_g     = r_grant;
        w_valid = bus.valid_i[r_grant];
      end
      default: begin
        w_g     = r_grant;
        w_valid = 1'b0;
      end
    endcase

    w_data = '0;
    w_last = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      if (lg_els_lp'(i) == w_g) begin
        w_data = bus.data_i[i*width_p +: width_p];
        w_last = bus.last_i[i];
      end
    end

    bus.ready_o = '0;
    for (int i = 0; i < els_p; i++) begin
      bus.ready_o[i] = bus.ready_i & (lg_els_lp'(i) == w_g)
                       & ((r_state == LOCKED) | bus.valid_i[i]);
    end

    bus.valid_o = w_valid;
    bus.data_o  = w_data;
    bus.last_o  = w_last;
    bus.tag_o   = w_g;

    w_accept  = w_valid & bus.ready_i;
    w_release = w_accept & (w_last | w_force);
    w_g_inc   = (w_g == lg_els_lp'(els_p - 1)) ? '0 : w_g + lg_els_lp'(1);
  end

  // Next-state process: any accepted beat that does not end the packet
  // (and is not force-released) leaves or keeps the arbiter LOCKED; the
  // end of a packet returns it to IDLE. Without a handshake nothing moves.
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      if (w_last | w_force) begin
        w_state_next = IDLE;
      end else begin
        w_state_next = LOCKED;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Priority pointer and held grant. Only the input that just finished a
  // packet loses priority (pointer moves to the one after it); an idle
  // pointer never drifts. The grant is captured when a packet opens.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      if (w_release) begin
        r_ptr <= w_g_inc;
      end
      if (w_accept && !w_release && (r_state == IDLE)) begin
        r_grant <= w_g;
      end
    end
  end

`ifdef BSG_RR_PKT_LEN_CHECK_EN
  localparam int beat_w_lp = $clog2(max_beats_p + 1);

  logic [beat_w_lp-1:0] r_beats;
  logic                 r_overlong;

  // Force-release when the max_beats_p-th beat of a packet goes through
  // without last. r_beats holds the number of beats already accepted, so
  // the beat being accepted now is number r_beats+1.
  assign w_force = w_accept & ~w_last
                   & (r_beats == beat_w_lp'(max_beats_p - 1));

  // Beat counter for the current packet plus the sticky error flag. The
  // counter clears whenever a packet ends, normally or by force.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_beats    <= '0;
      r_overlong <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last | w_force) begin
          r_beats <= '0;
        end else begin
          r_beats <= r_beats + beat_w_lp'(1);
        end
      end
      if (w_force) begin
        r_overlong <= 1'b1;
      end
    end
  end

  assign overlong_o = r_overlong;
`else
  // Packets are unbounded in this build; the error flag is constant low
  // whatever max_beats_p is set to.
  assign w_force    = 1'b0;
  assign overlong_o = (max_beats_p < 1) & 1'b0;
`endif

endmodule

// File: tb/tb_bsg_round_robin_n_to_1_pkt.sv
// ---------------------------------------------------------------------------
// tb_bsg_round_robin_n_to_1_pkt
//
// Bench for the packet-aware round-robin arbiter with els_p=3, width_p=8,
// max_beats_p=4. Directed scenarios use constant expectation tables; the
// randomized scenario compares against a packet-level reference model
// (who owns the output, who is next in line, beats in the current packet).
// Honours BSG_RR_PKT_LEN_CHECK_EN to pick the right expectations.
// ---------------------------------------------------------------------------
module tb_bsg_round_robin_n_to_1_pkt;

  localparam int ELS  = 3;
  localparam int W    = 8;
  localparam int MAXB = 4;

`ifdef BSG_RR_PKT_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [ELS-1:0] validIn;
  logic [ELS-1:0] lastIn;
  logic [ELS*W-1:0] dataIn;
  logic           readyIn;
  logic           overlong;

  bsg_round_robin_n_to_1_pkt_if #(.els_p(ELS), .width_p(W)) bus ();

  assign bus.valid_i = validIn;
  assign bus.last_i  = lastIn;
  assign bus.data_i  = dataIn;
  assign bus.ready_i = readyIn;

  bsg_round_robin_n_to_1_pkt #(
    .els_p(ELS), .width_p(W), .max_beats_p(MAXB)
  ) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .bus       (bus),
    .overlong_o(overlong)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: packet ownership, next-in-line pointer, beat count.
  bit       mLocked;
  int       mOwner;
  int       mPtr;
  int       mBeats;
  bit       mOverlong;

  bit             eValid;
  int             eTag;
  logic [W-1:0]   eData;
  bit             eLast;
  logic [ELS-1:0] eReady;

  // Expected outputs for the current inputs and model state.
  task automatic model_eval();
    int g;
    int c;
    g = -1;
    if (mLocked) begin
      g = mOwner;
      eValid = validIn[g];
    end else begin
      for (int k = 0; k < ELS; k++) begin
        c = (mPtr + k) % ELS;
        if (g < 0 && validIn[c]) g = c;
      end
      eValid = (g >= 0);
      if (g < 0) g = mPtr;
    end
    eTag  = g;
    eData = dataIn[g*W +: W];
    eLast = lastIn[g];
    for (int i = 0; i < ELS; i++)
      eReady[i] = readyIn && (i == g) && (mLocked || validIn[i]);
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_commit();
    if (rst) begin
      mLocked = 0; mOwner = 0; mPtr = 0; mBeats = 0; mOverlong = 0;
    end else if (eValid && readyIn) begin
      mBeats++;
      if (eLast) begin
        mLocked = 0; mPtr = (eTag + 1) % ELS; mBeats = 0;
      end else if (LEN_EN && mBeats == MAXB) begin
        mLocked = 0; mPtr = (eTag + 1) % ELS; mBeats = 0; mOverlong = 1;
      end else begin
        mLocked = 1; mOwner = eTag;
      end
    end
  endtask

  // One clock: update the model from the inputs seen at this edge, then
  // land 1 time unit after the edge ready for new stimulus.
  task automatic tick();
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles with nothing valid, then look at the idle outputs.
  task automatic test_reset();
    rst = 1; validIn = '0; lastIn = '0; dataIn = '0; readyIn = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid_o);
    end
    checks++;
    if (bus.tag_o !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_tag: got %0d expected 0", bus.tag_o);
    end
    checks++;
    if (bus.ready_o !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 000", bus.ready_o);
    end
    checks++;
    if (overlong !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_overlong: got %b expected 0", overlong);
    end
    tick();
  endtask

  // All inputs valid with single-beat packets: strict rotation 0,1,2,...
  task automatic test_fairness();
    int expTag[6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0] expReady;
    validIn = 3'b111; lastIn = 3'b111; readyIn = 1;
    dataIn = {8'h22, 8'h11, 8'h00};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      expReady = 3'b001 << expTag[c];
      checks++;
      if (bus.valid_o !== 1'b1 || bus.tag_o !== 2'(expTag[c]) ||
          bus.ready_o !== expReady || bus.data_o !== 8'(8'h11 * expTag[c])) begin
        errors++;
        $display("[TB] FAIL fairness cycle %0d: got valid=%b tag=%0d ready=%b data=%h, expected valid=1 tag=%0d ready=%b data=%h",
                 c, bus.valid_o, bus.tag_o, bus.ready_o, bus.data_o,
                 expTag[c], expReady, 8'(8'h11 * expTag[c]));
      end
      tick();
    end
  endtask

  // Input 1 owns the output for four beats with a bubble; 0 and 2 wait.
  task automatic test_packet_lock();
    logic [2:0] vSeq[7]   = '{3'b111, 3'b111, 3'b111, 3'b101, 3'b111, 3'b101, 3'b101};
    logic [7:0] dSeq[7]   = '{8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3, 8'hA3};
    bit         lSeq[7]   = '{0, 0, 0, 0, 1, 1, 1};
    bit         expV[7]   = '{1, 1, 1, 0, 1, 1, 1};
    int         expTag[7] = '{1, 1, 1, 1, 1, 2, 0};
    logic [7:0] expD[7]   = '{8'hA0, 8'hA1, 8'hA2, 8'h00, 8'hA3, 8'h22, 8'h00};
    logic [2:0] expR[7]   = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
    // Serve input 0 once so the pointer sits on input 1.
    validIn = 3'b001; lastIn = 3'b111; dataIn = {8'h22, 8'h11, 8'h00}; readyIn = 1;
    @(negedge clk);
    checks++;
    if (bus.tag_o !== 2'd0 || bus.valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL lock_prime: got tag=%0d valid=%b expected tag=0 valid=1", bus.tag_o, bus.valid_o);
    end
    tick();
    for (int c = 0; c < 7; c++) begin
      validIn = vSeq[c];
      lastIn  = {1'b1, lSeq[c], 1'b1};
      dataIn  = {8'h22, dSeq[c], 8'h00};
      @(negedge clk);
      checks++;
      if (bus.valid_o !== expV[c] || bus.tag_o !== 2'(expTag[c]) || bus.ready_o !== expR[c] ||
          (expV[c] && bus.data_o !== expD[c])) begin
        errors++;
        $display("[TB] FAIL packet_lock cycle %0d: got valid=%b tag=%0d ready=%b data=%h, expected valid=%b tag=%0d ready=%b data=%h",
                 c, bus.valid_o, bus.tag_o, bus.ready_o, bus.data_o,
                 expV[c], expTag[c], expR[c], expD[c]);
      end
      tick();
    end
  endtask

  // Stall the output in the middle of a packet on input 1.
  task automatic test_back_pressure();
    validIn = 3'b111; lastIn = 3'b101; dataIn = {8'h22, 8'hB0, 8'h00}; readyIn = 1;
    @(negedge clk);
    checks++;
    if (bus.tag_o !== 2'd1 || bus.data_o !== 8'hB0) begin
      errors++; $display("[TB] FAIL bp_first: got tag=%0d data=%h expected tag=1 data=b0", bus.tag_o, bus.data_o);
    end
    tick();
    dataIn = {8'h22, 8'hB1, 8'h00}; readyIn = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ready_o !== 3'b000 || bus.valid_o !== 1'b1 || bus.tag_o !== 2'd1 || bus.data_o !== 8'hB1) begin
        errors++;
        $display("[TB] FAIL bp_stall cycle %0d: got ready=%b valid=%b tag=%0d data=%h, expected ready=000 valid=1 tag=1 data=b1",
                 c, bus.ready_o, bus.valid_o, bus.tag_o, bus.data_o);
      end
      tick();
    end
    readyIn = 1;
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 3'b010 || bus.tag_o !== 2'd1 || bus.data_o !== 8'hB1) begin
      errors++; $display("[TB] FAIL bp_resume: got ready=%b tag=%0d data=%h expected ready=010 tag=1 data=b1", bus.ready_o, bus.tag_o, bus.data_o);
    end
    tick();
    dataIn = {8'h22, 8'hB2, 8'h00}; lastIn = 3'b111;
    @(negedge clk);
    checks++;
    if (bus.tag_o !== 2'd1 || bus.data_o !== 8'hB2 || bus.last_o !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_last: got tag=%0d data=%h last=%b expected tag=1 data=b2 last=1", bus.tag_o, bus.data_o, bus.last_o);
    end
    tick();
    validIn = 3'b101;
    @(negedge clk);
    checks++;
    if (bus.tag_o !== 2'd2 || bus.valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_next: got tag=%0d valid=%b expected tag=2 valid=1", bus.tag_o, bus.valid_o);
    end
    tick();
  endtask

  // Lock input 2 for two beats, reset, then everybody asks at once.
  task automatic test_reset_mid_packet();
    validIn = 3'b100; lastIn = 3'b000; dataIn = {8'hE0, 8'h11, 8'h00}; readyIn = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.tag_o !== 2'd2 || bus.valid_o !== 1'b1) begin
        errors++; $display("[TB] FAIL rmid_lock beat %0d: got tag=%0d valid=%b expected tag=2 valid=1", c, bus.tag_o, bus.valid_o);
      end
      tick();
      dataIn = {8'hE1, 8'h11, 8'h00};
    end
    rst = 1; validIn = 3'b111; lastIn = 3'b111;
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (bus.tag_o !== 2'd0 || bus.valid_o !== 1'b1 || bus.ready_o !== 3'b001) begin
      errors++; $display("[TB] FAIL rmid_grant: got tag=%0d valid=%b ready=%b expected tag=0 valid=1 ready=001", bus.tag_o, bus.valid_o, bus.ready_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.tag_o !== 2'd1 || bus.ready_o !== 3'b010) begin
      errors++; $display("[TB] FAIL rmid_idle: got tag=%0d ready=%b expected tag=1 ready=010", bus.tag_o, bus.ready_o);
    end
    tick();
  endtask

  // Six-beat packet on input 0 with input 1 waiting (limit is four beats).
  task automatic test_length_check();
    int beatIdx;
    bit served1;
`ifdef BSG_RR_PKT_LEN_CHECK_EN
    int         expTag[7] = '{0, 0, 0, 0, 1, 0, 0};
    logic [7:0] expD[7]   = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD1, 8'hC4, 8'hC5};
    bit         expOv[7]  = '{0, 0, 0, 0, 1, 1, 1};
`else
    int         expTag[7] = '{0, 0, 0, 0, 0, 0, 1};
    logic [7:0] expD[7]   = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hD1};
    bit         expOv[7]  = '{0, 0, 0, 0, 0, 0, 0};
`endif
    rst = 1; validIn = '0; tick(); rst = 0;
    beatIdx = 0; served1 = 0; readyIn = 1;
    for (int c = 0; c < 7; c++) begin
      validIn = {1'b0, !served1, beatIdx < 6};
      lastIn  = {1'b1, 1'b1, beatIdx == 5};
      dataIn  = {8'h22, 8'hD1, 8'(8'hC0 + beatIdx)};
      @(negedge clk);
      checks++;
      if (bus.tag_o !== 2'(expTag[c]) || bus.data_o !== expD[c] || bus.valid_o !== 1'b1 ||
          overlong !== expOv[c]) begin
        errors++;
        $display("[TB] FAIL length cycle %0d: got tag=%0d data=%h valid=%b overlong=%b, expected tag=%0d data=%h valid=1 overlong=%b",
                 c, bus.tag_o, bus.data_o, bus.valid_o, overlong, expTag[c], expD[c], expOv[c]);
      end
      if (bus.ready_o[0] && validIn[0]) beatIdx++;
      if (bus.ready_o[1] && validIn[1]) served1 = 1;
      tick();
    end
    checks++;
    if (beatIdx != 6 || !served1) begin
      errors++; $display("[TB] FAIL length_done: got beats=%0d served1=%b expected beats=6 served1=1", beatIdx, served1);
    end
    validIn = '0;
    tick(); tick(); tick();
    @(negedge clk);
    checks++;
    if (overlong !== LEN_EN) begin
      errors++; $display("[TB] FAIL length_sticky: got overlong=%b expected %b", overlong, LEN_EN);
    end
  endtask

  // Random traffic, back-pressure and occasional reset against the model.
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      validIn = 3'($urandom);
      lastIn  = 3'($urandom & $urandom);
      dataIn  = 24'($urandom);
      readyIn = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_eval();
      checks++;
      if (bus.valid_o !== eValid || bus.tag_o !== 2'(eTag) || bus.ready_o !== eReady ||
          overlong !== mOverlong) begin
        errors++;
        $display("[TB] FAIL random_ctrl cycle %0d: got valid=%b tag=%0d ready=%b overlong=%b, expected valid=%b tag=%0d ready=%b overlong=%b",
                 c, bus.valid_o, bus.tag_o, bus.ready_o, overlong, eValid, eTag, eReady, mOverlong);
      end
      if (eValid) begin
        checks++;
        if (bus.data_o !== eData || bus.last_o !== eLast) begin
          errors++;
          $display("[TB] FAIL random_data cycle %0d: got data=%h last=%b, expected data=%h last=%b",
                   c, bus.data_o, bus.last_o, eData, eLast);
        end
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    mLocked = 0; mOwner = 0; mPtr = 0; mBeats = 0; mOverlong = 0;
    test_reset();
    test_fairness();
    test_packet_lock();
    test_back_pressure();
    test_reset_mid_packet();
    test_length_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/bsg_round_robin_n_to_1_pkt.md
# bsg_round_robin_n_to_1_pkt

Packet-aware round-robin arbiter that merges `els_p` ready/valid input streams onto one output stream. It is the converging counterpart of the 1-to-N round-robin distributor and sits in front of shared links and FIFOs. A multi-beat packet holds the grant until its last beat is accepted, so packets from different inputs never interleave.

## Interface
- `els_p`, default 2: number of inputs, ≥ 2; `lg_els_lp = $clog2(els_p)`.
- `width_p`, default 8: data width per input.
- `max_beats_p`, default 16: packet-length limit; used only with the length-check feature.
- `clk_i` input 1: clock, rising edge.
- `reset_i` input 1: synchronous, active-high reset.
- `valid_i` input `els_p`: per-input valid.
- `data_i` input `els_p*width_p`: input `i` occupies bits `[i*width_p +: width_p]`.
- `last_i` input `els_p`: per-input end-of-packet marker, qualified by `valid_i`.
- `ready_o` output `els_p`: per-input ready.
- `valid_o` output 1: output valid.
- `data_o` output `width_p`: granted input's data.
- `last_o` output 1: granted input's `last_i`.
- `tag_o` output `lg_els_lp`: index of the granted input.
- `ready_i` input 1: output ready.
- `overlong_o` output 1: sticky packet-length error flag.

## Operation
- State: `IDLE` / `LOCKED`, `ptr_r` (`lg_els_lp` bits), `grant_r` (`lg_els_lp` bits).
- **IDLE**
  - Combinational search of `valid_i` starting at `ptr_r`, wrapping from `els_p-1` to 0. The first set bit is the grant `g`.
  - `valid_o = |valid_i`. `data_o`, `last_o` and `tag_o` come from input `g`.
- **LOCKED**
  - `g = grant_r`, `valid_o = valid_i[grant_r]`.
  - Bubbles from the locked input are allowed. Other inputs stay blocked even when valid.
- **All states**
  - `ready_o[i] = ready_i & (i == g) & (state == LOCKED | valid_i[i])`.
  - Beat accepted: `valid_o & ready_i`.
  - When `valid_o = 0`: `data_o` and `last_o` are don't-care and `tag_o = ptr_r` (IDLE) or `grant_r` (LOCKED).
- **Transitions**
  - IDLE, accepted beat with `last_o = 0`: go to LOCKED, `grant_r <= g`.
  - IDLE, accepted beat with `last_o = 1`: stay IDLE, `ptr_r <= g+1` mod `els_p`.
  - LOCKED, accepted beat with `last_o = 1`: go to IDLE, `ptr_r <= grant_r+1` mod `els_p`.
  - No accepted beat: state, `ptr_r` and `grant_r` hold.
- **Mod-`els_p` wrap:** explicit compare to `els_p-1`. Required for non-power-of-two `els_p`.
- `valid_o`, `data_o` and `tag_o` never depend combinationally on `ready_i`.
- Only the just-served input loses priority. An idle `ptr_r` does not advance without a handshake.

## Timing
- Zero-cycle latency: input to output is purely combinational.
- Decisions are registered on the `clk_i` edge where the handshake occurs.
- **Reset values:** state IDLE, `ptr_r = 0`, `grant_r = 0`, `overlong_o = 0`.
  - In the first post-reset cycle with no inputs valid: `valid_o = 0`, `tag_o = 0`, `ready_o = 0`.
- **Reset mid-packet:** the lock is abandoned and the next cycle arbitrates from input 0. Remaining beats of the cut packet are treated as new packets.
- **Back-pressure (`ready_i = 0`):** all `ready_o` are 0 and no state changes. An upstream that holds its valid beat sees `data_o` stable.

## Configuration
- Macro: `BSG_RR_PKT_LEN_CHECK_EN`.
- **Defined:**
  - A beat counter (`$clog2(max_beats_p+1)` bits) counts accepted beats of the current packet and is cleared when a packet ends.
  - If the `max_beats_p`-th beat is accepted with `last_o = 0`, the arbiter force-releases: next state IDLE, `ptr_r <= g+1` mod `els_p`, and `overlong_o` is set. `overlong_o` stays set until reset.
  - A packet of exactly `max_beats_p` beats ending in `last` is legal.
- **Undefined:** no counter, `overlong_o` tied 0, `max_beats_p` ignored, packets unbounded.

## Test plan
- **Reset and idle:** `els_p=3`, reset 2 cycles, `valid_i=000` -> `valid_o=0`, `tag_o=0`, `ready_o=000`, `overlong_o=0`.
- **Single-beat fairness:** `valid_i=111`, `last_i=111`, `ready_i=1` for 6 cycles -> `tag_o` sequence 0,1,2,0,1,2. Each `ready_o` is one-hot on the granted input.
- **Packet lock:**
  - Stimulus: `ptr_r=1`; input 1 sends 4 beats (data 0xA0–0xA3, last on 0xA3); inputs 0 and 2 are continuously valid; input 1 drops valid for 1 cycle after beat 2.
  - Required: `data_o` sequence A0, A1, A2, (`valid_o=0`), A3, all with `tag_o=1`; then `tag_o=2`, then `tag_o=0`.
- **Back-pressure:** mid-packet, `ready_i=0` for 5 cycles -> `ready_o=000`; `data_o`, `tag_o` and state unchanged; the packet resumes intact when `ready_i=1`.
- **Reset mid-packet:** input 2 locked after 2 beats, assert `reset_i` 1 cycle, then all inputs valid -> next grant is input 0, state IDLE.
- **Length check** (`BSG_RR_PKT_LEN_CHECK_EN`, `max_beats_p=4`):
  - 6-beat packet on input 0 with input 1 valid -> `overlong_o` rises the cycle after beat 4 and stays high.
  - Beat 5 waits, and input 1 is granted next.
  - Without the macro: all 6 beats are contiguous and `overlong_o=0`.
